// File: rtl/overlap_add.sv
// overlap_add: rebuilds a continuous sample stream from 50%-overlapped windowed frames.
// The first half of each frame is summed with the stored second half of the previous
// frame and emitted; the second half is stored for the next frame. A flush request
// drains the stored half-frame.
//
// Ports:
//   clk, rst      clock (rising edge) and asynchronous active-high reset
//   in_data_i     signed input sample; in_valid_i / in_ready_o handshake
//   in_last_i     final sample of a frame, qualified by in_valid_i
//   flush_i       single-cycle request to drain the stored tail
//   out_data_o    registered signed output sample; out_valid_o / out_ready_i handshake
//   out_last_o    last sample of a flush
//   frame_err_o   one-cycle pulse after an accept whose in_last disagrees with the index
module overlap_add #(
  parameter int unsigned FRAME_SIZE = 256,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_valid_i,
  input  logic                  in_last_i,
  output logic                  in_ready_o,
  input  logic                  flush_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_valid_o,
  output logic                  out_last_o,
  input  logic                  out_ready_i,
  output logic                  frame_err_o
);

  localparam int unsigned HOP  = FRAME_SIZE / 2;
  localparam int unsigned IdxW = $clog2(FRAME_SIZE);
  localparam int unsigned HopW = $clog2(HOP);
  localparam int unsigned CntW = HopW + 1;

  localparam logic [IdxW-1:0] IdxLast   = IdxW'(FRAME_SIZE - 1);
  localparam logic [IdxW-1:0] IdxHeadLast = IdxW'(HOP - 1);
  localparam logic [CntW-1:0] FlushEnd  = CntW'(HOP);
  localparam logic [CntW-1:0] FlushLast = CntW'(HOP - 1);

  localparam logic [DATA_WIDTH-1:0] SatMax = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SatMin = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StHead, StTail, StFlush} state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic                  tail_valid_q, tail_valid_d;
  logic [CntW-1:0]       flush_cnt_q, flush_cnt_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic                  frame_err_q, frame_err_d;

  logic [DATA_WIDTH-1:0] tail_q [HOP];
  logic                  tail_we;
  logic [HopW-1:0]       tail_idx;

  logic [DATA_WIDTH-1:0] prev;
  logic [DATA_WIDTH:0]   sum_wide;
  logic [DATA_WIDTH-1:0] sum_sat;
  logic                  out_free;
  logic                  flush_take;
  logic                  in_ready_c;

  // HOP is a power of two, so the low index bits address the tail in both halves
  // (idx in HEAD, idx-HOP in TAIL).
  assign tail_idx = idx_q[HopW-1:0];

  always_comb begin
    prev     = tail_valid_q ? tail_q[tail_idx] : '0;
    sum_wide = {prev[DATA_WIDTH-1], prev} + {in_data_i[DATA_WIDTH-1], in_data_i};
    // Overflow when the two top bits of the widened sum disagree.
    if (sum_wide[DATA_WIDTH] != sum_wide[DATA_WIDTH-1]) begin
      sum_sat = sum_wide[DATA_WIDTH] ? SatMin : SatMax;
    end else begin
      sum_sat = sum_wide[DATA_WIDTH-1:0];
    end
  end

  assign out_free   = !out_valid_q || out_ready_i;
  assign flush_take = (state_q == StHead) && flush_i && (idx_q == '0) && tail_valid_q;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    tail_valid_d = tail_valid_q;
    flush_cnt_d  = flush_cnt_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q && !out_ready_i;
    out_last_d   = out_last_q && !out_ready_i;
    frame_err_d  = 1'b0;
    tail_we      = 1'b0;
    in_ready_c   = 1'b0;

    unique case (state_q)
      StHead: begin
        // An honoured flush takes the cycle; no input is accepted alongside it.
        in_ready_c = out_free && !flush_take;
        if (flush_take) begin
          state_d = StFlush;
          if (out_free) begin
            // Load tail[0] now so the first flushed sample follows the flush edge.
            out_data_d  = tail_q[0];
            out_valid_d = 1'b1;
            out_last_d  = (FlushLast == '0);
            flush_cnt_d = CntW'(1);
          end else begin
            flush_cnt_d = '0;
          end
        end else if (in_valid_i && in_ready_c) begin
          out_data_d  = sum_sat;
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          if (in_last_i) begin
            // Early frame end: resync, next frame treated as the first.
            frame_err_d  = 1'b1;
            idx_d        = '0;
            tail_valid_d = 1'b0;
          end else begin
            idx_d = idx_q + IdxW'(1);
            if (idx_q == IdxHeadLast) state_d = StTail;
          end
        end
      end

      StTail: begin
        in_ready_c = 1'b1;
        if (in_valid_i) begin
          tail_we = 1'b1;
          if (idx_q == IdxLast) begin
            idx_d        = '0;
            tail_valid_d = 1'b1;
            state_d      = StHead;
            frame_err_d  = !in_last_i;
          end else if (in_last_i) begin
            frame_err_d  = 1'b1;
            idx_d        = '0;
            tail_valid_d = 1'b0;
            state_d      = StHead;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end

      StFlush: begin
        if (out_free && (flush_cnt_q != FlushEnd)) begin
          out_data_d  = tail_q[flush_cnt_q[HopW-1:0]];
          out_valid_d = 1'b1;
          out_last_d  = (flush_cnt_q == FlushLast);
          flush_cnt_d = flush_cnt_q + CntW'(1);
        end else if (out_valid_q && out_ready_i && out_last_q) begin
          state_d      = StHead;
          tail_valid_d = 1'b0;
          idx_d        = '0;
        end
      end

      default: state_d = StHead;
    endcase
  end

  assign in_ready_o = in_ready_c && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StHead;
      idx_q        <= '0;
      tail_valid_q <= 1'b0;
      flush_cnt_q  <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      tail_valid_q <= tail_valid_d;
      flush_cnt_q  <= flush_cnt_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Tail storage needs no reset: tail_valid masks stale contents.
  always_ff @(posedge clk) begin
    if (tail_we) tail_q[tail_idx] <= in_data_i;
  end

  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;
  assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_overlap_add.sv
// Testbench for overlap_add (FRAME_SIZE=8). A frame-level reference model pushes
// expected outputs into a scoreboard; an independent monitor pops on each output handshake.
module tb_overlap_add;
  localparam int FS  = 8;
  localparam int HOP = FS / 2;
  localparam int DW  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid, in_last, in_ready, flush;
  logic [DW-1:0] out_data;
  logic          out_valid, out_last, out_ready, frame_err;

  int total = 0;
  int bad   = 0;
  int pops  = 0;

  int exp_d[$];
  bit exp_l[$];

  // Reference model state: previous frame's second half and position in the frame.
  int m_tail[HOP];
  int m_new[HOP];
  bit m_tv;
  int m_idx;

  bit rand_rdy;
  int fr[FS];

  always #5 clk = ~clk;

  overlap_add #(.FRAME_SIZE(FS), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data_i  (in_data),
    .in_valid_i (in_valid),
    .in_last_i  (in_last),
    .in_ready_o (in_ready),
    .flush_i    (flush),
    .out_data_o (out_data),
    .out_valid_o(out_valid),
    .out_last_o (out_last),
    .out_ready_i(out_ready),
    .frame_err_o(frame_err)
  );

  function automatic int sat(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int rnd();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Downstream ready: random when enabled, otherwise left to the directed tests.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: a handshake visible at the negedge completes at the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_d.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got %0d, required no output", $signed(out_data));
        end else begin
          int d;
          bit l;
          d = exp_d.pop_front();
          l = exp_l.pop_front();
          check("out_data", $signed(out_data), d);
          check("out_last", out_last, l);
          pops++;
        end
      end
    end
  end

  // Offer one sample, update the model, wait for acceptance, check frame_err afterwards.
  task automatic put(input int x, input bit l, output int stalls);
    bit at_end;
    bit err;
    bit rdy;
    bit done;
    at_end = (m_idx == FS - 1);
    err    = (l != at_end);
    if (m_idx < HOP) begin
      exp_d.push_back(sat((m_tv ? m_tail[m_idx] : 0) + x));
      exp_l.push_back(1'b0);
    end else begin
      m_new[m_idx - HOP] = x;
    end
    if (at_end) begin
      m_tail = m_new;
      m_tv   = 1'b1;
      m_idx  = 0;
    end else if (l) begin
      m_tv  = 1'b0;
      m_idx = 0;
    end else begin
      m_idx++;
    end

    in_data  = DW'(x);
    in_last  = l;
    in_valid = 1'b1;
    stalls   = 0;
    done     = 1'b0;
    while (!done) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) done = 1'b1;
      else begin
        stalls++;
        if (stalls > 300) begin
          check("accept_timeout", stalls, 0);
          done = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("frame_err", frame_err, err);
  endtask

  task automatic send_frame(input int n, input int last_pos, input bit chk_rate);
    int st;
    for (int i = 0; i < n; i++) begin
      put(fr[i], (i == last_pos), st);
      if (chk_rate) check("rate_stall", st, 0);
    end
  endtask

  task automatic do_flush();
    if (m_tv && m_idx == 0) begin
      for (int i = 0; i < HOP; i++) begin
        exp_d.push_back(m_tail[i]);
        exp_l.push_back(i == HOP - 1);
      end
      m_tv = 1'b0;
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_d.size() != 0 || out_valid) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_done", (n < 500), 1);
  endtask

  initial begin
    int st;
    int p0;
    int held;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    flush    = 1'b0;
    rand_rdy = 1'b0;
    m_tv     = 1'b0;
    m_idx    = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_frame_err", frame_err, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Flush with nothing stored: no output, block stays ready.
    p0 = pops;
    do_flush();
    repeat (5) @(posedge clk);
    #1;
    check("noflush_pops", pops - p0, 0);
    check("noflush_out_valid", out_valid, 0);
    check("noflush_in_ready", in_ready, 1);

    // Overlap-add of 1..8 and 10..80, then flush, full rate.
    out_ready = 1'b1;
    for (int i = 0; i < FS; i++) fr[i] = i + 1;
    send_frame(FS, FS - 1, 1'b1);
    for (int i = 0; i < FS; i++) fr[i] = 10 * (i + 1);
    send_frame(FS, FS - 1, 1'b1);
    wait_drain();
    p0 = pops;
    do_flush();
    wait_drain();
    check("flush_count", pops - p0, HOP);

    // Saturation both ways, random downstream ready.
    rand_rdy = 1'b1;
    for (int i = 0; i < FS; i++) fr[i] = $urandom_range(0, 100);
    fr[HOP] = 30000;
    fr[HOP + 1] = -30000;
    send_frame(FS, FS - 1, 1'b0);
    for (int i = 0; i < FS; i++) fr[i] = $urandom_range(0, 100);
    fr[0] = 10000;
    fr[1] = -10000;
    send_frame(FS, FS - 1, 1'b0);

    // Backpressure during HEAD.
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    out_ready = 1'b0;
    for (int i = 0; i < FS; i++) fr[i] = rnd();
    put(fr[0], 1'b0, st);
    check("bp_first_stall", st, 0);
    held     = exp_d[0];
    in_data  = DW'(fr[1]);
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_out_hold", $signed(out_data), held);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 1; i < FS; i++) begin
      put(fr[i], (i == FS - 1), st);
      if (i > 1) check("bp_rate_stall", st, 0);
    end

    // Early in_last at idx 5, then a frame with no stored tail.
    rand_rdy = 1'b1;
    for (int i = 0; i < FS; i++) fr[i] = rnd();
    send_frame(6, 5, 1'b0);
    @(posedge clk);
    #1;
    check("frame_err_width", frame_err, 0);
    for (int i = 0; i < FS; i++) fr[i] = rnd();
    send_frame(FS, FS - 1, 1'b0);

    // Reset mid-frame at idx 5, then frame C of all 7s.
    for (int i = 0; i < FS; i++) fr[i] = rnd();
    send_frame(5, -1, 1'b0);
    rst = 1'b1;
    exp_d.delete();
    exp_l.delete();
    m_tv  = 1'b0;
    m_idx = 0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_out_last", out_last, 0);
    check("mid_rst_frame_err", frame_err, 0);
    check("mid_rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < FS; i++) fr[i] = 7;
    send_frame(FS, FS - 1, 1'b0);

    // Flush at idx != 0 is ignored; flush at idx 0 drains exactly HOP samples.
    for (int i = 0; i < FS; i++) fr[i] = rnd();
    put(fr[0], 1'b0, st);
    put(fr[1], 1'b0, st);
    do_flush();
    for (int i = 2; i < FS; i++) put(fr[i], (i == FS - 1), st);
    wait_drain();
    p0 = pops;
    do_flush();
    wait_drain();
    check("flush_drain_count", pops - p0, HOP);

    // Random frames with occasional framing faults and flushes.
    for (int f = 0; f < 30; f++) begin
      int kind;
      kind = $urandom_range(0, 9);
      for (int i = 0; i < FS; i++) fr[i] = rnd();
      if (kind == 0) send_frame($urandom_range(1, FS - 1), -2, 1'b0);
      else if (kind == 1) send_frame(FS, -1, 1'b0);
      else if (kind == 2) begin
        if (m_idx == 0) begin
          do_flush();
          wait_drain();
        end
      end else send_frame(FS, FS - 1, 1'b0);
      if (kind == 0) begin
        // Early end: last flag on the final offered sample.
        for (int i = 0; i < FS; i++) fr[i] = rnd();
        send_frame(1, 0, 1'b0);
      end
    end
    if (m_idx == 0) do_flush();
    wait_drain();
    check("final_queue_empty", exp_d.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

endmodule

// File: doc/overlap_add.md
# overlap_add

Synthesis-side counterpart of the analysis framer: reassembles a stream of 50 %-overlapped, windowed frames into one continuous sample stream by overlap-add. It sits downstream of any frame-domain processing (enhancement, inverse-FFT path) and accepts frames exactly as the framer emits them: FRAME_SIZE samples per frame and a hop of FRAME_SIZE/2. It uses valid/ready handshakes on both sides, supports output backpressure, and flushes the final half-frame on request.

## Interface
- FRAME_SIZE, 256, samples per input frame; even, ≥4, power of two.
- DATA_WIDTH, 16, sample width; signed two's complement on both sides.
- HOP (localparam), FRAME_SIZE/2, overlap depth and tail-buffer depth.

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_data  in  DATA_WIDTH  windowed frame sample.
- in_valid  in  1  in_data valid.
- in_last  in  1  marks the final sample of a frame; qualified by in_valid.
- in_ready  out  1  block accepts in_data this cycle.
- flush  in  1  single-cycle request to drain the stored tail.
- out_data  out  DATA_WIDTH  reconstructed sample (registered).
- out_valid  out  1  out_data valid.
- out_last  out  1  set on the last sample of a flush.
- out_ready  in  1  downstream accepts out_data.
- frame_err  out  1  one-cycle pulse on an in_last/index mismatch.

## Operation
- Index counter idx, range 0..FRAME_SIZE-1, counts accepted input samples. Tail buffer: HOP entries × DATA_WIDTH. The tail_valid flag records that the buffer holds the second half of the previous frame.
- States are HEAD (idx < HOP), TAIL (idx ≥ HOP) and FLUSH.
- HEAD: each accepted sample produces an output.
  - prev = tail_valid ? tail[idx] : 0.
  - sum = prev + in_data, computed in DATA_WIDTH+1 bits and saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - The sum is loaded into out_data, and out_valid is set.
- TAIL: each accepted sample is written to tail[idx-HOP] and produces no output. When idx reaches FRAME_SIZE-1 the sample is accepted, idx wraps to 0, tail_valid is set, and the state returns to HEAD.
- in_ready (combinational):
  - HEAD: !out_valid || out_ready.
  - TAIL: 1.
  - FLUSH: 0.
  - 0 while rst is asserted.
- The output register holds its value while out_valid && !out_ready. out_valid clears when out_ready is high and no new sample is loaded in that cycle.
- flush is honoured only in HEAD with idx==0; otherwise it is ignored.
  - If tail_valid=0, flush is a no-op.
  - If tail_valid=1, the state goes to FLUSH, which emits tail[0..HOP-1] in order, one per output handshake, with out_last=1 on tail[HOP-1].
  - After the last flushed handshake: tail_valid=0, the state goes to HEAD, and idx=0.
- Framing checks:
  - in_last accepted with idx≠FRAME_SIZE-1: frame_err pulses. The sample is processed normally for its state, then idx=0, tail_valid=0, and the state goes to HEAD (resync; the next frame is treated as the first).
  - idx==FRAME_SIZE-1 accepted without in_last: frame_err pulses, and the normal wrap still occurs with tail_valid set.
- Reset (async, at any time, including mid-frame or mid-flush):
  - idx=0, state=HEAD, tail_valid=0.
  - out_data=0, out_valid=0, out_last=0, frame_err=0.
  - Tail buffer contents are don't-care, because tail_valid masks them.

## Timing
- Latency: an input accepted in HEAD at edge n appears on out_data/out_valid after edge n (registered, 1 cycle).
- Throughput: 1 sample/cycle in both HEAD and TAIL with out_ready held high. The steady-state output rate is HOP outputs per FRAME_SIZE inputs.
- FLUSH: one output per cycle with out_ready held high. The first flushed sample is valid after the edge following flush.
- frame_err: asserted for exactly the one cycle following the offending accept.
- out_last: valid only with out_valid; it is 0 for every non-flush sample.

## Test plan
Tests 1–4 use FRAME_SIZE=8 (HOP=4).
1. **Overlap-add and flush.**
   - Stimulus: frame A = 1..8, then frame B = 10,20,…,80 (in_last on each 8th sample), then flush.
   - Required outputs: 1,2,3,4, then 15,26,37,48, then 50,60,70,80, with out_last only on 80.
2. **Saturation.**
   - Stimulus: tail sample 30000 plus head sample 10000.
   - Required output: 32767.
   - Stimulus: -30000 plus -10000.
   - Required output: -32768.
3. **Backpressure.**
   - Stimulus: hold out_ready=0 for 5 cycles during HEAD.
   - Required response: in_ready=0 throughout, out_data stable, no sample lost or duplicated. The TAIL samples of the same frame are still accepted at 1/cycle once HEAD completes.
4. **Early in_last.**
   - Stimulus: in_last on the 6th sample (idx=5).
   - Required response: frame_err pulses for 1 cycle. The next frame's head outputs equal its raw inputs (prev=0).
5. **Reset mid-frame.**
   - Stimulus: assert rst at idx=5, then feed frame C = 7,7,…
   - Required response: all outputs read 0 immediately after rst. C's first 4 outputs are 7 (no stale tail).
6. **Flush edge cases.**
   - Stimulus: flush with tail_valid=0, and flush at idx≠0.
   - Required response: no output and no state change in either case. A flush at idx=0 after a frame drains exactly HOP samples.
